flappy_collision_scorer: RTL and testbench
==========================================

# flappy_collision_scorer

Game-state controller sitting directly downstream of the obstacle generator: consumes the current obstacle position/gap heights plus the bird's vertical position, detects collisions, counts cleared obstacles as a 3-digit BCD score, and runs the IDLE/PLAYING/DEAD game FSM. Its `obstacle_restart` and `playing` outputs drive the obstacle generator's restart and motion, and its score/high-score outputs feed the HEX display driver.

## Interface
- `BIRD_X`, 160: fixed left column of the bird sprite.
- `BIRD_SIZE`, 16: bird sprite width and height, in pixels.
- `OBSTACLE_WIDTH`, 40: pipe width, in pixels; `obs_x` is the pipe's left edge.
- `HOLD_TICKS`, 60: number of ticks in DEAD before `start` is accepted.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle frame-step pulse, shared with the obstacle/bird movers.
- `start`  in  1  one-cycle debounced flap/start pulse.
- `bird_y`  in  9  top row of the bird, 0..479.
- `obs_x`  in  10  obstacle left edge, 0..639.
- `obs_y_top`  in  9  top pipe height; it covers rows `0 .. obs_y_top-1`.
- `obs_y_bot`  in  9  bottom pipe height; it covers rows `480-obs_y_bot .. 479`.
- `playing`  out  1  high while in PLAYING.
- `game_over`  out  1  high while in DEAD.
- `collision`  out  1  one-cycle pulse on the fatal tick.
- `obstacle_restart`  out  1  one-cycle pulse on entry to PLAYING.
- `score_bcd`  out  12  current score, three packed BCD digits.
- `hi_score_bcd`  out  12  best score since reset, three packed BCD digits.

## Operation
- FSM states: IDLE, PLAYING, DEAD. Reset state is IDLE.
- IDLE to PLAYING on `start`. The transition clears the score, clears `scored`, and pulses `obstacle_restart`.
- PLAYING to DEAD on a `tick` cycle where `hit` is true. That cycle:
  - pulses `collision`;
  - loads `hi_score_bcd` with `score_bcd` if `score_bcd` is greater (packed BCD compares correctly as unsigned 12-bit);
  - loads the hold counter with `HOLD_TICKS`.
- DEAD: the hold counter decrements on each `tick`. `start` is ignored while the counter is nonzero. Once it is zero, `start` moves to PLAYING with the same entry actions as from IDLE.
- Hit rule (all arithmetic in 11 bits, no wrap). `hit` is true when any of these holds:
  - x-overlap and top-pipe contact: `BIRD_X+BIRD_SIZE > obs_x` and `BIRD_X < obs_x+OBSTACLE_WIDTH`, and `bird_y < obs_y_top`;
  - x-overlap and bottom-pipe contact: same x-overlap, and `bird_y+BIRD_SIZE > 480-obs_y_bot`;
  - ground contact: `bird_y+BIRD_SIZE >= 480`, regardless of x.
- Scoring:
  - Register `prev_x` is updated with `obs_x` on every `tick` in PLAYING.
  - On a PLAYING `tick`, if `scored` is 0 and `obs_x+OBSTACLE_WIDTH <= BIRD_X`, increment the score and set `scored`.
  - `obs_x > prev_x` on a tick means a new obstacle has spawned; this clears `scored`.
- Score increments in BCD and saturates at 999.
- Simultaneous events:
  - hit and score-eligible on the same tick: hit wins, no increment;
  - `start` and `tick` in the same IDLE/DEAD cycle: transition taken, tick not evaluated.
- Inputs are evaluated only on `tick` cycles in PLAYING. Outside PLAYING the score and `prev_x` hold.

## Timing
- All outputs are registered and update on the clock edge ending the qualifying cycle, i.e. 1-cycle latency from `tick`/`start`.
- Reset values: state IDLE; `playing`, `game_over`, `collision`, `obstacle_restart` = 0; `score_bcd` = `hi_score_bcd` = 12'h000; hold counter = 0; `prev_x` = 0; `scored` = 0.
- Reset mid-game returns to IDLE in one cycle and clears the high score as well.
- `collision` and `obstacle_restart` are never high for more than one cycle, and never high together.
- `playing` and `game_over` are mutually exclusive.

## Structure
- The shared `Constants` package holds screen width/height (640/480), `OBSTACLE_WIDTH`, `BIRD_X`, `BIRD_SIZE`, and a `game_state_t` enum {IDLE, PLAYING, DEAD}. Parameters default to these constants.
- Sub-module `bcd_counter3` is a 3-digit saturating BCD counter with `clr`, `inc`, and `q[11:0]`. The score uses one instance; the high score is a plain register.

## Test plan
- Reset then `start`: `obstacle_restart` pulses once, `playing`=1, score 000.
- `bird_y`=200, `obs_y_top`=150, `obs_y_bot`=150. Step `obs_x` from 200 down to 100 over ticks: no collision. Score becomes 001 on the tick where `obs_x`=120, and stays 001 for later ticks.
- `obs_x` jumps 0 to 600, then steps down to 120: score becomes 002.
- `bird_y`=140 with `obs_x`=150, `obs_y_top`=150 on a tick: `collision` pulses; DEAD; `hi_score_bcd`=002. `start` during hold is ignored. After 60 ticks, `start` restarts with score 000 and high score 002.
- `bird_y`=464 on a tick with `obs_x`=600: ground hit, DEAD.
- Force the score to 999, then clear another obstacle: score stays 999. Assert `reset` mid-PLAYING: next cycle IDLE, all outputs at reset values.

Source files
------------

// File: rtl/flappy_collision_scorer_pkg.sv
// Shared game constants, the game-state enum and a packed-BCD increment helper.
package flappy_collision_scorer_pkg;

    localparam int SCREEN_W       = 640;
    localparam int SCREEN_H       = 480;
    localparam int OBSTACLE_WIDTH = 40;
    localparam int BIRD_X         = 160;
    localparam int BIRD_SIZE      = 16;
    localparam int HOLD_TICKS     = 60;

    localparam logic [11:0] BCD_MAX = 12'h999;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        DEAD    = 2'd2
    } game_state_t;

    // Three-digit packed BCD increment that saturates at 999.
    function automatic logic [11:0] bcd_inc3(input logic [11:0] q);
        logic [11:0] r;
        r = q;
        if (q == BCD_MAX) begin
            r = q;
        end else if (q[3:0] != 4'd9) begin
            r[3:0] = q[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (q[7:4] != 4'd9) begin
                r[7:4] = q[7:4] + 4'd1;
            end else begin
                r[7:4]  = 4'd0;
                r[11:8] = q[11:8] + 4'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/flappy_collision_scorer_if.sv
// Game-state bus between the obstacle/bird side (master) and the scorer (slave).
interface flappy_collision_scorer_if;

    logic        tick;
    logic        start;
    logic [8:0]  bird_y;
    logic [9:0]  obs_x;
    logic [8:0]  obs_y_top;
    logic [8:0]  obs_y_bot;
    logic        playing;
    logic        game_over;
    logic        collision;
    logic        obstacle_restart;
    logic [11:0] score_bcd;
    logic [11:0] hi_score_bcd;

    modport master (
        output tick, start, bird_y, obs_x, obs_y_top, obs_y_bot,
        input  playing, game_over, collision, obstacle_restart, score_bcd, hi_score_bcd
    );

    modport slave (
        input  tick, start, bird_y, obs_x, obs_y_top, obs_y_bot,
        output playing, game_over, collision, obstacle_restart, score_bcd, hi_score_bcd
    );

endinterface

// File: rtl/flappy_collision_scorer_bcd_counter3.sv
// Three-digit packed-BCD counter with synchronous clear and saturation at 999.
module bcd_counter3
    import flappy_collision_scorer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clr,
    input  logic        i_inc,
    output logic [11:0] o_q
);

    logic [11:0] r_q;

    // Clear has priority over increment; increment saturates inside bcd_inc3.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= 12'h000;
        end else if (i_clr) begin
            r_q <= 12'h000;
        end else if (i_inc) begin
            r_q <= bcd_inc3(r_q);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/flappy_collision_scorer.sv
// Flappy game controller: collision detection, BCD scoring and IDLE/PLAYING/DEAD FSM.
module flappy_collision_scorer #(
    parameter int BIRD_X         = flappy_collision_scorer_pkg::BIRD_X,
    parameter int BIRD_SIZE      = flappy_collision_scorer_pkg::BIRD_SIZE,
    parameter int OBSTACLE_WIDTH = flappy_collision_scorer_pkg::OBSTACLE_WIDTH,
    parameter int HOLD_TICKS     = flappy_collision_scorer_pkg::HOLD_TICKS
) (
    input  logic                      clk,
    input  logic                      reset,
    flappy_collision_scorer_if.slave  io_game
);

    import flappy_collision_scorer_pkg::*;

    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    localparam logic [10:0]       C_BIRD_X    = 11'(BIRD_X);
    localparam logic [10:0]       C_BIRD_SIZE = 11'(BIRD_SIZE);
    localparam logic [10:0]       C_OBS_W     = 11'(OBSTACLE_WIDTH);
    localparam logic [10:0]       C_SCREEN_H  = 11'(SCREEN_H);
    localparam logic [HOLD_W-1:0] C_HOLD      = HOLD_W'(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] C_HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] C_HOLD_ONE  = HOLD_W'(1);

    game_state_t       r_state;
    logic              r_playing;
    logic              r_game_over;
    logic              r_collision;
    logic              r_obstacle_restart;
    logic [11:0]       r_hi_score;
    logic [HOLD_W-1:0] r_hold;
    logic [9:0]        r_prev_x;
    logic              r_scored;

    logic [10:0] w_bird_y;
    logic [10:0] w_obs_x;
    logic [10:0] w_obs_top;
    logic [10:0] w_obs_bot;
    logic        w_x_overlap;
    logic        w_hit;
    logic        w_clear_pos;
    logic        w_new_obs;
    logic        w_play_tick;
    logic        w_fatal;
    logic        w_score_inc;
    logic        w_enter;
    logic [11:0] w_score;

    // All geometry is widened to 11 bits so no sum can wrap.
    assign w_bird_y  = {2'b00, io_game.bird_y};
    assign w_obs_x   = {1'b0, io_game.obs_x};
    assign w_obs_top = {2'b00, io_game.obs_y_top};
    assign w_obs_bot = {2'b00, io_game.obs_y_bot};

    // Bottom-pipe test is rearranged as y+size+bot > H so 480-obs_y_bot is never formed.
    assign w_x_overlap = ((C_BIRD_X + C_BIRD_SIZE) > w_obs_x) && (C_BIRD_X < (w_obs_x + C_OBS_W));
    assign w_hit       = (w_x_overlap && (w_bird_y < w_obs_top))
                       || (w_x_overlap && ((w_bird_y + C_BIRD_SIZE + w_obs_bot) > C_SCREEN_H))
                       || ((w_bird_y + C_BIRD_SIZE) >= C_SCREEN_H);
    assign w_clear_pos = (w_obs_x + C_OBS_W) <= C_BIRD_X;
    assign w_new_obs   = io_game.obs_x > r_prev_x;

    // Per-cycle event decode: game entry, fatal tick, and score increment (hit wins).
    always_comb begin
        w_play_tick = 1'b0;
        w_fatal     = 1'b0;
        w_score_inc = 1'b0;
        w_enter     = 1'b0;
        case (r_state)
            IDLE: begin
                w_enter = io_game.start;
            end
            PLAYING: begin
                w_play_tick = io_game.tick;
                w_fatal     = io_game.tick && w_hit;
                w_score_inc = io_game.tick && !w_hit && !r_scored && w_clear_pos;
            end
            DEAD: begin
                if (r_hold == C_HOLD_ZERO) begin
                    w_enter = io_game.start;
                end else begin
                    w_enter = 1'b0;
                end
            end
            default: begin
                w_enter = 1'b0;
            end
        endcase
    end

    bcd_counter3 u_score (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_enter),
        .i_inc (w_score_inc),
        .o_q   (w_score)
    );

    // Game FSM with registered status/pulse outputs, hold timer, prev_x and scored flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= IDLE;
            r_playing          <= 1'b0;
            r_game_over        <= 1'b0;
            r_collision        <= 1'b0;
            r_obstacle_restart <= 1'b0;
            r_hi_score         <= 12'h000;
            r_hold             <= C_HOLD_ZERO;
            r_prev_x           <= 10'd0;
            r_scored           <= 1'b0;
        end else begin
            r_collision        <= 1'b0;
            r_obstacle_restart <= 1'b0;
            if (w_enter) begin
                r_state            <= PLAYING;
                r_playing          <= 1'b1;
                r_game_over        <= 1'b0;
                r_obstacle_restart <= 1'b1;
                r_scored           <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    PLAYING: begin
                        if (w_play_tick) begin
                            r_prev_x <= io_game.obs_x;
                            if (w_fatal) begin
                                r_state     <= DEAD;
                                r_playing   <= 1'b0;
                                r_game_over <= 1'b1;
                                r_collision <= 1'b1;
                                r_hold      <= C_HOLD;
                                if (w_score > r_hi_score) begin
                                    r_hi_score <= w_score;
                                end
                            end else if (w_score_inc) begin
                                r_scored <= 1'b1;
                            end else if (w_new_obs) begin
                                r_scored <= 1'b0;
                            end
                        end
                    end
                    DEAD: begin
                        if (io_game.tick && (r_hold != C_HOLD_ZERO)) begin
                            r_hold <= r_hold - C_HOLD_ONE;
                        end
                    end
                    default: begin
                        r_state     <= IDLE;
                        r_playing   <= 1'b0;
                        r_game_over <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign io_game.playing          = r_playing;
    assign io_game.game_over        = r_game_over;
    assign io_game.collision        = r_collision;
    assign io_game.obstacle_restart = r_obstacle_restart;
    assign io_game.score_bcd        = w_score;
    assign io_game.hi_score_bcd     = r_hi_score;

endmodule

// File: tb/tb_flappy_collision_scorer.sv
// Directed testbench for flappy_collision_scorer with an integer-level game model.
module tb_flappy_collision_scorer;

    logic clk;
    logic reset;

    flappy_collision_scorer_if bus ();

    flappy_collision_scorer dut (
        .clk     (clk),
        .reset   (reset),
        .io_game (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: 0 idle, 1 playing, 2 dead; score kept as a plain integer.
    int m_state  = 0;
    int m_score  = 0;
    int m_hi     = 0;
    int m_hold   = 0;
    int m_prev_x = 0;
    bit m_scored = 1'b0;
    bit m_coll   = 1'b0;
    bit m_rst_p  = 1'b0;

    function automatic logic [11:0] to_bcd(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic bit model_hit(input int by, input int ox, input int top, input int bot);
        bit xo;
        xo = (160 + 16 > ox) && (160 < ox + 40);
        return (xo && (by < top)) || (xo && (by + 16 > 480 - bot)) || (by + 16 >= 480);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_enter();
        m_state   = 1;
        m_score   = 0;
        m_scored  = 1'b0;
        m_rst_p   = 1'b1;
    endtask

    task automatic model_step();
        int ox;
        ox = int'(bus.obs_x);
        m_coll  = 1'b0;
        m_rst_p = 1'b0;
        if (reset) begin
            m_state = 0; m_score = 0; m_hi = 0; m_hold = 0; m_prev_x = 0; m_scored = 1'b0;
        end else if (m_state == 0) begin
            if (bus.start) model_enter();
        end else if (m_state == 1) begin
            if (bus.tick) begin
                if (model_hit(int'(bus.bird_y), ox, int'(bus.obs_y_top), int'(bus.obs_y_bot))) begin
                    m_state = 2;
                    m_coll  = 1'b1;
                    m_hold  = 60;
                    if (m_score > m_hi) m_hi = m_score;
                end else if (!m_scored && (ox + 40 <= 160)) begin
                    m_score  = (m_score < 999) ? m_score + 1 : 999;
                    m_scored = 1'b1;
                end else if (ox > m_prev_x) begin
                    m_scored = 1'b0;
                end
                m_prev_x = ox;
            end
        end else begin
            if (m_hold == 0 && bus.start) model_enter();
            else if (bus.tick && m_hold > 0) m_hold = m_hold - 1;
        end
    endtask

    task automatic compare_all();
        chk("playing",   bus.playing,          32'(m_state == 1));
        chk("game_over", bus.game_over,        32'(m_state == 2));
        chk("collision", bus.collision,        32'(m_coll));
        chk("restart",   bus.obstacle_restart, 32'(m_rst_p));
        chk("score",     bus.score_bcd,        32'(to_bcd(m_score)));
        chk("hi_score",  bus.hi_score_bcd,     32'(to_bcd(m_hi)));
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic tick_at(input int ox);
        bus.obs_x = 10'(ox);
        bus.tick  = 1'b1;
        cycle();
        bus.tick  = 1'b0;
        cycle();
    endtask

    task automatic hold_then_start();
        for (int i = 0; i < 60; i++) begin
            bus.tick = 1'b1;
            cycle();
        end
        bus.tick  = 1'b0;
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        chk("restart_after_hold", bus.playing, 32'd1);
        cycle();
    endtask

    initial begin
        reset         = 1'b1;
        bus.tick      = 1'b0;
        bus.start     = 1'b0;
        bus.bird_y    = 9'd200;
        bus.obs_x     = 10'd0;
        bus.obs_y_top = 9'd150;
        bus.obs_y_bot = 9'd150;
        cycle();
        cycle();
        chk("reset_score", bus.score_bcd, 32'h000);
        chk("reset_playing", bus.playing, 32'd0);
        reset = 1'b0;
        cycle();

        // start together with tick in IDLE: transition taken
        bus.start = 1'b1;
        bus.tick  = 1'b1;
        cycle();
        bus.start = 1'b0;
        bus.tick  = 1'b0;
        chk("start_restart_pulse", bus.obstacle_restart, 32'd1);
        chk("start_playing", bus.playing, 32'd1);
        cycle();
        chk("restart_one_cycle", bus.obstacle_restart, 32'd0);

        // first obstacle passes, score 001 at obs_x=120
        for (int x = 200; x >= 100; x -= 10) begin
            tick_at(x);
            if (x == 130) chk("score_before_120", bus.score_bcd, 32'h000);
            if (x == 120) chk("score_at_120", bus.score_bcd, 32'h001);
        end
        chk("score_hold_001", bus.score_bcd, 32'h001);
        chk("no_collision_pass", bus.game_over, 32'd0);

        // second obstacle
        tick_at(0);
        for (int x = 600; x >= 120; x -= 40) tick_at(x);
        chk("score_002", bus.score_bcd, 32'h002);

        // top-pipe hit
        bus.bird_y = 9'd140;
        bus.obs_x  = 10'd150;
        bus.tick   = 1'b1;
        cycle();
        bus.tick   = 1'b0;
        chk("top_hit_collision", bus.collision, 32'd1);
        chk("top_hit_dead", bus.game_over, 32'd1);
        chk("top_hit_hi", bus.hi_score_bcd, 32'h002);
        cycle();
        chk("collision_one_cycle", bus.collision, 32'd0);
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        chk("start_ignored_in_hold", bus.playing, 32'd0);
        for (int i = 0; i < 59; i++) begin
            bus.tick = 1'b1;
            cycle();
            bus.tick = 1'b0;
            cycle();
        end
        // 60th tick with start: counter still 1, start ignored
        bus.tick  = 1'b1;
        bus.start = 1'b1;
        cycle();
        chk("start_ignored_last_tick", bus.playing, 32'd0);
        // counter now 0: start with tick is accepted
        cycle();
        bus.tick  = 1'b0;
        bus.start = 1'b0;
        chk("restart_playing", bus.playing, 32'd1);
        chk("restart_score", bus.score_bcd, 32'h000);
        chk("restart_hi", bus.hi_score_bcd, 32'h002);
        bus.bird_y = 9'd200;
        cycle();

        // boundaries: no contact exactly at the pipe and screen edges
        bus.bird_y = 9'd150; tick_at(150);
        bus.bird_y = 9'd314; tick_at(150);
        bus.bird_y = 9'd100; tick_at(176);
        bus.bird_y = 9'd463; tick_at(600);
        chk("edges_no_hit", bus.playing, 32'd1);

        // ground hit on the same tick the pipe becomes score-eligible: hit wins
        bus.bird_y = 9'd464;
        tick_at(100);
        chk("ground_hit_dead", bus.game_over, 32'd1);
        chk("ground_hit_no_inc", bus.score_bcd, 32'h000);
        chk("ground_hit_hi_kept", bus.hi_score_bcd, 32'h002);
        bus.bird_y = 9'd200;
        hold_then_start();

        // ground hit far from the pipe
        bus.bird_y = 9'd464;
        tick_at(600);
        chk("ground_hit_far", bus.game_over, 32'd1);
        bus.bird_y = 9'd200;
        hold_then_start();

        // drive score to saturation
        for (int i = 0; i < 1100 && m_score < 999; i++) begin
            tick_at(600);
            tick_at(100);
        end
        chk("score_999", bus.score_bcd, 32'h999);
        tick_at(600);
        tick_at(100);
        chk("score_saturated", bus.score_bcd, 32'h999);

        // reset mid-game
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("midreset_playing", bus.playing, 32'd0);
        chk("midreset_score", bus.score_bcd, 32'h000);
        chk("midreset_hi", bus.hi_score_bcd, 32'h000);
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
